csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
- Initiator side of the CSR read/write bus and trap-control interface of the single-cycle core's CSR register file.
- Accepts one decoded SYSTEM instruction at a time over a valid/ready request channel: CSRRW/S/C, CSRRWI/SI/CI, ECALL, EBREAK, MRET.
- Sequences the CSR bus strobes, drives trap entry (ent_trap, mepc, mcause) and returns rd data plus a PC redirect on a valid/ready response channel.

Parameters:
XLEN, 32, data/address width of CSR values and PC

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_type  in  2  00 CSR op, 01 ECALL, 10 EBREAK, 11 MRET
req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
req_addr  in  12  CSR address
req_rs1_val  in  XLEN  rs1 value (register forms)
req_uimm  in  5  rs1 field / zimm
req_pc  in  XLEN  PC of the instruction
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  XLEN  old CSR value for rd (0 for non-CSR ops)
rsp_redirect  out  1  PC must be redirected to rsp_target
rsp_target  out  XLEN  redirect target
csr_read, csr_write, csr_set, csr_clear  out  1 each  CSR bus strobes
csr_addr  out  12  CSR bus address
csr_wdata  out  XLEN  CSR bus write data
csr_rdata  in  XLEN  CSR bus read data (combinational)
ent_trap  out  1  trap entry pulse
csr_wr_mepc_mepc  out  XLEN  mepc HW write value
csr_wr_mcause_exception_code  out  XLEN-1  mcause code
csr_wr_mcause_interrupt  out  1  mcause interrupt bit (always 0)
csr_rd_mtvec_base  in  XLEN-2  mtvec base
csr_rd_mtvec_mode  in  2  mtvec mode
csr_rd_mepc_mepc  in  XLEN  current mepc

Behaviour:
- Clocking/reset: single clock clk; rst_b asynchronous, active-low. Reset forces state IDLE, clears all captured registers and response outputs.
- While rst_b is low, all outputs are 0, including req_ready, every strobe, ent_trap and rsp_valid.
- Reset mid-operation abandons the request with no further strobes or response.
- FSM states: IDLE, RD, WR, TRAP, RESP. req_ready=1 only in IDLE; no bypass, so at most one request is outstanding.
- IDLE, on req_valid, captures all req_* fields and branches on req_type:
  - CSR op with legal req_op goes to RD.
  - CSR op with funct3 000 or 100 goes to RESP with rdata=0, redirect=0, and no bus activity.
  - ECALL/EBREAK go to TRAP.
  - MRET captures csr_rd_mepc_mepc as target, sets redirect=1, goes to RESP.
- RD (1 cycle):
  - csr_read=1 and csr_addr=captured address; csr_rdata is registered into rsp_rdata.
  - Go to WR if a write is required, else RESP.
  - Write required: RW/RWI always; RS/RC/RSI/RCI only when req_uimm != 0.
- WR (1 cycle):
  - Exactly one of csr_write (RW/RWI), csr_set (RS/RSI) or csr_clear (RC/RCI) is asserted.
  - csr_read=1 is also asserted in this cycle, because the register file forms set/clear data from csr_rdata.
  - csr_wdata = req_rs1_val for register forms, or {XLEN-5 zeros, req_uimm} for immediate forms.
  - Next state RESP.
- TRAP (1 cycle):
  - ent_trap=1, csr_wr_mepc_mepc=captured PC, csr_wr_mcause_interrupt=0.
  - csr_wr_mcause_exception_code = 11 for ECALL, 3 for EBREAK.
  - rsp_target = {csr_rd_mtvec_base, 2'b00} for every mode: vectored mode only offsets interrupts, and modes 2/3 are treated as direct. rsp_redirect=1.
  - Next state RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_redirect/rsp_target held stable until rsp_ready; then go to IDLE. rsp_ready may already be high on entry.
- Strobes, csr_addr, csr_wdata, ent_trap and the HW-write values are combinational from state, and are 0 outside their own state.
- Latency from the accept edge N, with rsp_ready=1: MRET/illegal respond at N+1, CSR read-only at N+2, CSR with write at N+3, traps at N+2.
- Next accept is possible one cycle after the response handshake.

Test Plan:
- Reset: hold rst_b=0 → all outputs 0. Release → req_ready=1, rsp_valid=0.
- CSRRW: mtvec=0x00000100, rs1=0x80000000 → RD cycle with csr_read only, then WR cycle with csr_write+csr_read and wdata=0x80000000. Response rdata=0x100, redirect=0 at N+3.
- CSRRS and CSRRCI on mepc=0x0000F0F0:
  - CSRRS rs1=0x0000000F, uimm=5 → csr_set asserted, rdata=0xF0F0, mepc becomes 0xF0FF.
  - CSRRCI uimm=0 → no WR cycle, response at N+2.
- ECALL at pc=0x80000010 with mtvec=0x80000101 (mode 1) → one-cycle ent_trap, mepc=0x80000010, code=11, interrupt=0. Response redirect=1, target=0x80000100.
- MRET with mepc=0x80000014 → response at N+1: redirect=1, target=0x80000014. No strobes at any point.
- Backpressure plus mid-op reset:
  - rsp_ready=0 for 5 cycles → response stable and req_ready=0 throughout.
  - Assert rst_b during WR → strobes drop immediately and no response is produced.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl_if
// Description : Request/response, CSR bus and trap-control signals of the
//               CSR access controller, grouped with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_access_ctrl_if #(
    parameter int XLEN = 32
);
    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [2:0]        req_op;
    logic [11:0]       req_addr;
    logic [XLEN-1:0]   req_rs1_val;
    logic [4:0]        req_uimm;
    logic [XLEN-1:0]   req_pc;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_redirect;
    logic [XLEN-1:0]   rsp_target;

    // CSR bus
    logic              csr_read;
    logic              csr_write;
    logic              csr_set;
    logic              csr_clear;
    logic [11:0]       csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;

    // Trap control
    logic              ent_trap;
    logic [XLEN-1:0]   csr_wr_mepc_mepc;
    logic [XLEN-2:0]   csr_wr_mcause_exception_code;
    logic              csr_wr_mcause_interrupt;
    logic [XLEN-3:0]   csr_rd_mtvec_base;
    logic [1:0]        csr_rd_mtvec_mode;
    logic [XLEN-1:0]   csr_rd_mepc_mepc;

    // Controller view
    modport master (
        input  req_valid,
        output req_ready,
        input  req_type,
        input  req_op,
        input  req_addr,
        input  req_rs1_val,
        input  req_uimm,
        input  req_pc,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_redirect,
        output rsp_target,
        output csr_read,
        output csr_write,
        output csr_set,
        output csr_clear,
        output csr_addr,
        output csr_wdata,
        input  csr_rdata,
        output ent_trap,
        output csr_wr_mepc_mepc,
        output csr_wr_mcause_exception_code,
        output csr_wr_mcause_interrupt,
        input  csr_rd_mtvec_base,
        input  csr_rd_mtvec_mode,
        input  csr_rd_mepc_mepc
    );

    // Core / register-file view
    modport slave (
        output req_valid,
        input  req_ready,
        output req_type,
        output req_op,
        output req_addr,
        output req_rs1_val,
        output req_uimm,
        output req_pc,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_redirect,
        input  rsp_target,
        input  csr_read,
        input  csr_write,
        input  csr_set,
        input  csr_clear,
        input  csr_addr,
        input  csr_wdata,
        output csr_rdata,
        input  ent_trap,
        input  csr_wr_mepc_mepc,
        input  csr_wr_mcause_exception_code,
        input  csr_wr_mcause_interrupt,
        output csr_rd_mtvec_base,
        output csr_rd_mtvec_mode,
        output csr_rd_mepc_mepc
    );
endinterface
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl
// Description : Sequences CSR read/modify strobes, trap entry and MRET for one
//               SYSTEM instruction at a time, returning rd data and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_ctrl #(
    parameter int XLEN = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_b,
    csr_access_ctrl_if.master  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_TRAP = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] T_CSR    = 2'b00;
    localparam logic [1:0] T_ECALL  = 2'b01;
    localparam logic [1:0] T_EBREAK = 2'b10;
    localparam logic [1:0] T_MRET   = 2'b11;

    localparam logic [1:0] F_RW = 2'b01;
    localparam logic [1:0] F_RS = 2'b10;
    localparam logic [1:0] F_RC = 2'b11;

    localparam logic [XLEN-2:0] CODE_ECALL  = (XLEN-1)'(11);
    localparam logic [XLEN-2:0] CODE_EBREAK = (XLEN-1)'(3);

    logic [2:0]      state_q, state_d;
    logic [1:0]      type_q;
    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] rs1_q;
    logic [4:0]      uimm_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] target_q, target_d;

    logic            w_accept;
    logic            w_op_legal;
    logic            w_wr_needed;
    logic            w_in_rd;
    logic            w_in_wr;
    logic            w_in_trap;
    logic            w_unused_mode;

    assign w_accept   = (state_q == S_IDLE) && bus.req_valid;
    assign w_op_legal = (bus.req_op[1:0] != 2'b00);
    // Set/clear with a zero source is a pure read and must not touch the CSR.
    assign w_wr_needed = (op_q[1:0] == F_RW) || (uimm_q != 5'd0);

    assign w_in_rd   = (state_q == S_RD);
    assign w_in_wr   = (state_q == S_WR);
    assign w_in_trap = (state_q == S_TRAP);

    // mtvec mode does not affect exception entry; only the base is used.
    assign w_unused_mode = ^bus.csr_rd_mtvec_mode;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        redirect_d = redirect_q;
        target_d   = target_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rdata_d    = '0;
                    redirect_d = 1'b0;
                    target_d   = '0;
                    case (bus.req_type)
                        T_CSR:    state_d = w_op_legal ? S_RD : S_RESP;
                        T_ECALL,
                        T_EBREAK: state_d = S_TRAP;
                        T_MRET: begin
                            target_d   = bus.csr_rd_mepc_mepc;
                            redirect_d = 1'b1;
                            state_d    = S_RESP;
                        end
                        default:  state_d = S_RESP;
                    endcase
                end
            end
            S_RD: begin
                rdata_d = bus.csr_rdata;
                state_d = w_wr_needed ? S_WR : S_RESP;
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_TRAP: begin
                target_d   = {bus.csr_rd_mtvec_base, 2'b00};
                redirect_d = 1'b1;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            type_q     <= 2'b00;
            op_q       <= 3'b000;
            addr_q     <= 12'h000;
            rs1_q      <= '0;
            uimm_q     <= 5'd0;
            pc_q       <= '0;
            rdata_q    <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            if (w_accept) begin
                type_q <= bus.req_type;
                op_q   <= bus.req_op;
                addr_q <= bus.req_addr;
                rs1_q  <= bus.req_rs1_val;
                uimm_q <= bus.req_uimm;
                pc_q   <= bus.req_pc;
            end
        end
    end

    // Handshake outputs; req_ready is forced low while reset is held.
    assign bus.req_ready    = rst_b && (state_q == S_IDLE);
    assign bus.rsp_valid    = (state_q == S_RESP);
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_redirect = redirect_q;
    assign bus.rsp_target   = target_q;

    // Read stays high in WR because the register file builds set/clear data
    // from the current value it is presenting on csr_rdata.
    assign bus.csr_read  = w_in_rd || w_in_wr;
    assign bus.csr_write = w_in_wr && (op_q[1:0] == F_RW);
    assign bus.csr_set   = w_in_wr && (op_q[1:0] == F_RS);
    assign bus.csr_clear = w_in_wr && (op_q[1:0] == F_RC);
    assign bus.csr_addr  = (w_in_rd || w_in_wr) ? addr_q : 12'h000;
    assign bus.csr_wdata = !w_in_wr ? '0 :
                           op_q[2]  ? {{(XLEN-5){1'b0}}, uimm_q} : rs1_q;

    assign bus.ent_trap                     = w_in_trap;
    assign bus.csr_wr_mepc_mepc             = w_in_trap ? pc_q : '0;
    assign bus.csr_wr_mcause_exception_code = !w_in_trap           ? '0 :
                                              (type_q == T_ECALL)  ? CODE_ECALL
                                                                   : CODE_EBREAK;
    assign bus.csr_wr_mcause_interrupt      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_ctrl
// Description : Self-checking bench with a CSR register-file environment and
//               an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_ctrl;

    localparam int XLEN = 32;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MSCR    = 12'h340;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    csr_access_ctrl_if #(.XLEN(XLEN)) bus();

    csr_access_ctrl #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // Environment register file (driven by DUT strobes) and reference model
    logic [31:0] mem   [0:4095];
    logic [31:0] model [0:4095];
    logic        bd_we   = 1'b0;
    logic [11:0] bd_addr = 12'h0;
    logic [31:0] bd_data = 32'h0;
    int n_rd = 0, n_wr = 0, n_set = 0, n_clr = 0, n_trap = 0;
    int n_checks = 0, n_fail = 0;

    assign bus.csr_rdata         = mem[bus.csr_addr];
    assign bus.csr_rd_mtvec_base = mem[A_MTVEC][31:2];
    assign bus.csr_rd_mtvec_mode = mem[A_MTVEC][1:0];
    assign bus.csr_rd_mepc_mepc  = mem[A_MEPC];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus.csr_read) n_rd <= n_rd + 1;
        if (bus.csr_write) begin
            mem[bus.csr_addr] <= bus.csr_wdata;
            n_wr <= n_wr + 1;
        end
        if (bus.csr_set) begin
            mem[bus.csr_addr] <= mem[bus.csr_addr] | bus.csr_wdata;
            n_set <= n_set + 1;
        end
        if (bus.csr_clear) begin
            mem[bus.csr_addr] <= mem[bus.csr_addr] & ~bus.csr_wdata;
            n_clr <= n_clr + 1;
        end
        if (bus.ent_trap) begin
            mem[A_MEPC]   <= bus.csr_wr_mepc_mepc;
            mem[A_MCAUSE] <= {bus.csr_wr_mcause_interrupt, bus.csr_wr_mcause_exception_code};
            n_trap <= n_trap + 1;
        end
    end

    task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        model[a] = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one instruction, predicts its architectural effect, and checks
    // latency, response fields, strobe counts and resulting CSR contents.
    task automatic run_op(input string name, input logic [1:0] t, input logic [2:0] op,
                          input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] uimm,
                          input logic [31:0] pc, input int hold);
        logic [31:0] old, src, e_rdata, e_target, f_rdata, f_target;
        logic        e_redir, f_redir;
        int e_lat, e_rd, e_wr, e_set, e_clr, e_trap, k;
        int b_rd, b_wr, b_set, b_clr, b_trap;
        bit got;
        e_rdata = 0; e_target = 0; e_redir = 0; e_lat = 1;
        e_rd = 0; e_wr = 0; e_set = 0; e_clr = 0; e_trap = 0;
        if (t == 2'b00) begin
            if (op[1:0] != 2'b00) begin
                old = model[a];
                e_rdata = old;
                src = op[2] ? {27'b0, uimm} : rs1;
                e_rd = 1; e_lat = 2;
                if (op[1:0] == 2'b01 || uimm != 0) begin
                    e_rd = 2; e_lat = 3;
                    if (op[1:0] == 2'b01)      begin model[a] = src;        e_wr  = 1; end
                    else if (op[1:0] == 2'b10) begin model[a] = old | src;  e_set = 1; end
                    else                       begin model[a] = old & ~src; e_clr = 1; end
                end
            end
        end else if (t == 2'b11) begin
            e_redir = 1; e_target = model[A_MEPC];
        end else begin
            e_lat = 2; e_trap = 1; e_redir = 1;
            e_target = {model[A_MTVEC][31:2], 2'b00};
            model[A_MEPC]   = pc;
            model[A_MCAUSE] = (t == 2'b01) ? 32'd11 : 32'd3;
        end

        b_rd = n_rd; b_wr = n_wr; b_set = n_set; b_clr = n_clr; b_trap = n_trap;
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        bus.req_type = t; bus.req_op = op; bus.req_addr = a;
        bus.req_rs1_val = rs1; bus.req_uimm = uimm; bus.req_pc = pc;
        bus.req_valid = 1'b1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready before accept: got %b expected 1", name, bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_rs1_val = $urandom; bus.req_pc = $urandom;

        got = 0; k = 0;
        while (!got && k < 12) begin
            @(negedge clk); k++;
            if (bus.rsp_valid === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s response timeout: got none expected rsp_valid", name);
            bus.rsp_ready = 1'b1;
            return;
        end
        n_checks++;
        if (k != e_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, k, e_lat);
        end
        n_checks++;
        if (bus.rsp_rdata !== e_rdata) begin
            n_fail++; $display("FAIL %s rdata: got %h expected %h", name, bus.rsp_rdata, e_rdata);
        end
        n_checks++;
        if (bus.rsp_redirect !== e_redir) begin
            n_fail++; $display("FAIL %s redirect: got %b expected %b", name, bus.rsp_redirect, e_redir);
        end
        if (e_redir) begin
            n_checks++;
            if (bus.rsp_target !== e_target) begin
                n_fail++; $display("FAIL %s target: got %h expected %h", name, bus.rsp_target, e_target);
            end
        end
        f_rdata = bus.rsp_rdata; f_redir = bus.rsp_redirect; f_target = bus.rsp_target;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== f_rdata ||
                bus.rsp_redirect !== f_redir || bus.rsp_target !== f_target) begin
                n_fail++;
                $display("FAIL %s stall cycle %0d: got valid=%b ready=%b rdata=%h expected valid=1 ready=0 rdata=%h",
                         name, i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, f_rdata);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s after handshake: got valid=%b ready=%b expected valid=0 ready=1",
                               name, bus.rsp_valid, bus.req_ready);
        end
        n_checks++;
        if ((n_rd - b_rd) != e_rd || (n_wr - b_wr) != e_wr || (n_set - b_set) != e_set ||
            (n_clr - b_clr) != e_clr || (n_trap - b_trap) != e_trap) begin
            n_fail++;
            $display("FAIL %s strobe counts: got rd=%0d wr=%0d set=%0d clr=%0d trap=%0d expected %0d %0d %0d %0d %0d",
                     name, n_rd - b_rd, n_wr - b_wr, n_set - b_set, n_clr - b_clr, n_trap - b_trap,
                     e_rd, e_wr, e_set, e_clr, e_trap);
        end
        n_checks++;
        if (mem[a] !== model[a] || mem[A_MEPC] !== model[A_MEPC] || mem[A_MCAUSE] !== model[A_MCAUSE]) begin
            n_fail++;
            $display("FAIL %s csr contents: got csr=%h mepc=%h mcause=%h expected %h %h %h", name,
                     mem[a], mem[A_MEPC], mem[A_MCAUSE], model[a], model[A_MEPC], model[A_MCAUSE]);
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
        bus.req_type = 0; bus.req_op = 0; bus.req_addr = 0;
        bus.req_rs1_val = 0; bus.req_uimm = 0; bus.req_pc = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_redirect, bus.csr_read, bus.csr_write,
             bus.csr_set, bus.csr_clear, bus.ent_trap, bus.csr_wr_mcause_interrupt} !== 9'b0 ||
            |{bus.rsp_rdata, bus.rsp_target, bus.csr_addr, bus.csr_wdata,
              bus.csr_wr_mepc_mepc, bus.csr_wr_mcause_exception_code} !== 1'b0) begin
            n_fail++; $display("FAIL reset outputs: got req_ready=%b rsp_valid=%b rd=%b expected all 0",
                               bus.req_ready, bus.rsp_valid, bus.csr_read);
        end
        rst_b = 1'b1; #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset release: got req_ready=%b rsp_valid=%b expected 1/0",
                               bus.req_ready, bus.rsp_valid);
        end
        foreach (model[i]) model[i] = 32'h0;
        set_csr(12'h000, 32'h0);
        set_csr(A_MSTATUS, 32'h0);
        set_csr(A_MSCR, 32'h0);
        set_csr(A_MCAUSE, 32'h0);
    endtask

    task automatic test_csrrw;
        set_csr(A_MTVEC, 32'h0000_0100);
        run_op("csrrw_mtvec", 2'b00, 3'b001, A_MTVEC, 32'h8000_0000, 5'd3, 32'h0, 0);
    endtask

    task automatic test_set_clear;
        set_csr(A_MEPC, 32'h0000_F0F0);
        run_op("csrrs_mepc", 2'b00, 3'b010, A_MEPC, 32'h0000_000F, 5'd5, 32'h0, 0);
        run_op("csrrci_zero", 2'b00, 3'b111, A_MEPC, 32'hFFFF_FFFF, 5'd0, 32'h0, 0);
        run_op("csrrsi_imm", 2'b00, 3'b110, A_MSCR, 32'hFFFF_FFFF, 5'd18, 32'h0, 0);
        run_op("csrrc_reg", 2'b00, 3'b011, A_MEPC, 32'h0000_00F0, 5'd7, 32'h0, 0);
        run_op("csrrwi_imm", 2'b00, 3'b101, A_MSTATUS, 32'hDEAD_BEEF, 5'd31, 32'h0, 0);
        run_op("illegal_000", 2'b00, 3'b000, A_MEPC, 32'h1234_5678, 5'd9, 32'h0, 0);
        run_op("illegal_100", 2'b00, 3'b100, A_MEPC, 32'h1234_5678, 5'd9, 32'h0, 0);
    endtask

    task automatic test_traps;
        set_csr(A_MTVEC, 32'h8000_0101);
        run_op("ecall", 2'b01, 3'b000, 12'h000, 32'h0, 5'd0, 32'h8000_0010, 0);
        set_csr(A_MTVEC, 32'h0000_2003);
        run_op("ebreak_mode3", 2'b10, 3'b000, 12'h000, 32'h0, 5'd0, 32'h0000_0444, 0);
        set_csr(A_MEPC, 32'h8000_0014);
        run_op("mret", 2'b11, 3'b000, 12'h000, 32'h0, 5'd0, 32'h0, 0);
    endtask

    task automatic test_backpressure;
        set_csr(A_MSCR, 32'hA5A5_0000);
        run_op("stall_csrrs", 2'b00, 3'b010, A_MSCR, 32'h0000_5A5A, 5'd1, 32'h0, 5);
        run_op("stall_ecall", 2'b01, 3'b000, 12'h000, 32'h0, 5'd0, 32'h0000_0800, 5);
    endtask

    task automatic test_midop_reset;
        set_csr(A_MSCR, 32'h1111_2222);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_type = 2'b00; bus.req_op = 3'b001; bus.req_addr = A_MSCR;
        bus.req_rs1_val = 32'h3333_4444; bus.req_uimm = 5'd1; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.csr_read !== 1'b1 || bus.csr_write !== 1'b0 || bus.csr_addr !== A_MSCR) begin
            n_fail++; $display("FAIL midop rd cycle: got rd=%b wr=%b addr=%h expected 1/0/%h",
                               bus.csr_read, bus.csr_write, bus.csr_addr, A_MSCR);
        end
        @(negedge clk);
        n_checks++;
        if (bus.csr_read !== 1'b1 || bus.csr_write !== 1'b1 || bus.csr_wdata !== 32'h3333_4444) begin
            n_fail++; $display("FAIL midop wr cycle: got rd=%b wr=%b wdata=%h expected 1/1/33334444",
                               bus.csr_read, bus.csr_write, bus.csr_wdata);
        end
        rst_b = 1'b0; #1;
        n_checks++;
        if ({bus.csr_read, bus.csr_write, bus.rsp_valid, bus.req_ready} !== 4'b0) begin
            n_fail++; $display("FAIL midop reset outputs: got rd=%b wr=%b valid=%b ready=%b expected 0",
                               bus.csr_read, bus.csr_write, bus.rsp_valid, bus.req_ready);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.csr_write !== 1'b0) begin
                n_fail++; $display("FAIL midop after reset %0d: got valid=%b ready=%b expected 0/1",
                                   i, bus.rsp_valid, bus.req_ready);
            end
        end
        n_checks++;
        if (mem[A_MSCR] !== model[A_MSCR]) begin
            n_fail++; $display("FAIL midop csr kept: got %h expected %h", mem[A_MSCR], model[A_MSCR]);
        end
    endtask

    task automatic test_random;
        logic [11:0] alist [4];
        logic [1:0]  t;
        int r;
        alist[0] = A_MSTATUS; alist[1] = A_MTVEC; alist[2] = A_MSCR; alist[3] = A_MEPC;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            t = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
            run_op($sformatf("rand%0d", n), t, 3'($urandom), alist[$urandom_range(0, 3)],
                   $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_set_clear();
        test_traps();
        test_backpressure();
        test_midop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
